// File: rtl/uart_irq_scheduler.sv
// UART interrupt scheduler: latches one-cycle interrupt events and picks the highest-priority
// unmasked pending source. It drives a registered IRQ line and INTID and sequences ack/clear
// in NORMAL or FAST_CLEAR response mode.
// Optional: define UART_IRQ_VECTOR_EN to add vectored_i / vector_o (ISR vector output).
module uart_irq_scheduler (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] event_i,
  input  logic [7:0] int_mask_i,
  input  logic [1:0] response_mode_i,
  input  logic       int_ackn_i,
`ifdef UART_IRQ_VECTOR_EN
  input  logic       vectored_i,
  output logic [7:0] vector_o,
`endif
  output logic       irq_o,
  output logic [2:0] int_id_o,
  output logic [7:0] pending_o,
  output logic       int_pending_o
);

  // Interrupt ids; the bit index in event_i / pending equals the id.
  localparam logic [2:0] IntTxDone     = 3'b000;
  localparam logic [2:0] IntConfigFail = 3'b001;
  localparam logic [2:0] IntOverrun    = 3'b010;
  localparam logic [2:0] IntFrame      = 3'b011;
  localparam logic [2:0] IntParity     = 3'b100;
  localparam logic [2:0] IntRxdRdy     = 3'b101;
  localparam logic [2:0] IntRxFull     = 3'b110;
  localparam logic [2:0] IntConfigReq  = 3'b111;

  // Only FAST_CLEAR is decoded; every other code behaves as NORMAL.
  localparam logic [1:0] ModeFastClear = 2'b01;

  typedef enum logic [2:0] {
    StIdle,
    StPrio1WaitAckn,
    StPrio1Clear,
    StPrio2WaitAckn,
    StPrio2Clear,
    StPrio3WaitAckn,
    StPrio3Clear
  } normal_interrupt_response_fsm_e;

  normal_interrupt_response_fsm_e state_q, win_wait, clear_state;

  logic [7:0] pending_q, pending_d, eligible, clear_mask;
  logic [2:0] int_id_q, win_id;
  logic       fast_q, irq_q, irq_next, win_valid, in_wait, clear_req;

  // Fixed-priority winner among pending sources whose mask is still set.
  always_comb begin
    eligible  = pending_q & int_mask_i;
    win_valid = |eligible;
    win_id    = IntTxDone;
    win_wait  = StPrio3WaitAckn;
    if (eligible[IntConfigFail]) begin
      win_id   = IntConfigFail;
      win_wait = StPrio1WaitAckn;
    end else if (eligible[IntOverrun]) begin
      win_id   = IntOverrun;
      win_wait = StPrio1WaitAckn;
    end else if (eligible[IntFrame]) begin
      win_id   = IntFrame;
      win_wait = StPrio1WaitAckn;
    end else if (eligible[IntParity]) begin
      win_id   = IntParity;
      win_wait = StPrio1WaitAckn;
    end else if (eligible[IntRxFull]) begin
      win_id   = IntRxFull;
      win_wait = StPrio2WaitAckn;
    end else if (eligible[IntRxdRdy]) begin
      win_id   = IntRxdRdy;
      win_wait = StPrio2WaitAckn;
    end else if (eligible[IntConfigReq]) begin
      win_id   = IntConfigReq;
      win_wait = StPrio3WaitAckn;
    end
  end

  // Wait-state decode, clear request and the next value of the registered IRQ line.
  always_comb begin
    in_wait = (state_q == StPrio1WaitAckn) || (state_q == StPrio2WaitAckn) ||
              (state_q == StPrio3WaitAckn);
    // FAST_CLEAR leaves WAIT after one cycle regardless of int_ackn_i.
    clear_req  = in_wait && (fast_q || int_ackn_i);
    clear_mask = clear_req ? (8'b0000_0001 << int_id_q) : 8'h00;
    irq_next   = ((state_q == StIdle) && win_valid) || (in_wait && !clear_req);
    case (state_q)
      StPrio1WaitAckn: clear_state = StPrio1Clear;
      StPrio2WaitAckn: clear_state = StPrio2Clear;
      StPrio3WaitAckn: clear_state = StPrio3Clear;
      default:         clear_state = StIdle;
    endcase
    // A new event wins over a clear of the same bit.
    pending_d = (pending_q & ~clear_mask) | (event_i & int_mask_i);
  end

  // Pending register; masked events are dropped, not deferred.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pending_q <= 8'h00;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Response FSM with registered irq/int_id; mode is sampled only on IDLE->WAIT.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= StIdle;
      int_id_q <= IntTxDone;
      fast_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_q <= irq_next;
      case (state_q)
        StIdle: begin
          if (win_valid) begin
            state_q  <= win_wait;
            int_id_q <= win_id;
            fast_q   <= (response_mode_i == ModeFastClear);
          end
        end
        StPrio1WaitAckn, StPrio2WaitAckn, StPrio3WaitAckn: begin
          if (clear_req) state_q <= clear_state;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef UART_IRQ_VECTOR_EN
  localparam logic [7:0] UartIsrVector = 8'hFF;

  logic [7:0] vector_q;

  // Vector tracks the registered IRQ, gated by the vectored-mode control bit.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vector_q <= 8'h00;
    end else begin
      vector_q <= (irq_next && vectored_i) ? UartIsrVector : 8'h00;
    end
  end

  assign vector_o = vector_q;
`endif

  assign irq_o         = irq_q;
  assign int_id_o      = int_id_q;
  assign pending_o     = pending_q;
  assign int_pending_o = |pending_q;

endmodule

// File: tb/tb_uart_irq_scheduler.sv
// Self-checking bench for uart_irq_scheduler; expected INTIDs queue up when events are driven
// and are popped when the IRQ rises. Honours UART_IRQ_VECTOR_EN for the vector port.
module tb_uart_irq_scheduler;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic [7:0] event_i;
  logic [7:0] int_mask_i;
  logic [1:0] response_mode_i;
  logic       int_ackn_i;
  logic       irq_o;
  logic [2:0] int_id_o;
  logic [7:0] pending_o;
  logic       int_pending_o;
`ifdef UART_IRQ_VECTOR_EN
  logic       vectored_i;
  logic [7:0] vector_o;
`endif

  int checks   = 0;
  int failures = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_id;

  always #5 clk_i = ~clk_i;

  uart_irq_scheduler dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .event_i         (event_i),
    .int_mask_i      (int_mask_i),
    .response_mode_i (response_mode_i),
    .int_ackn_i      (int_ackn_i),
`ifdef UART_IRQ_VECTOR_EN
    .vectored_i      (vectored_i),
    .vector_o        (vector_o),
`endif
    .irq_o           (irq_o),
    .int_id_o        (int_id_o),
    .pending_o       (pending_o),
    .int_pending_o   (int_pending_o)
  );

  // Inputs change and outputs are read 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_event(input logic [7:0] ev);
    event_i = ev;
    tick();
    event_i = 8'h00;
  endtask

  task automatic pulse_ack();
    int_ackn_i = 1'b1;
    tick();
    int_ackn_i = 1'b0;
  endtask

  // Bounded wait for irq_o; callers compare irq_o afterwards, so a timeout shows as a FAIL.
  task automatic wait_irq(input int budget, output int waited);
    waited = 0;
    while (irq_o !== 1'b1 && waited < budget) begin
      tick();
      waited++;
    end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b1;
    event_i = 8'h00;
    int_mask_i = 8'hFF;
    response_mode_i = 2'b00;
    int_ackn_i = 1'b0;
`ifdef UART_IRQ_VECTOR_EN
    vectored_i = 1'b0;
`endif
    #1 rst_n_i = 1'b0;
    #1;
    checks++;
    if (irq_o !== 1'b0) begin
      failures++; $display("FAIL reset_irq: got %b expected 0", irq_o);
    end
    checks++;
    if (int_id_o !== 3'b000) begin
      failures++; $display("FAIL reset_id: got %b expected 000", int_id_o);
    end
    checks++;
    if (pending_o !== 8'h00 || int_pending_o !== 1'b0) begin
      failures++; $display("FAIL reset_pending: got %h/%b expected 00/0", pending_o, int_pending_o);
    end
    repeat (2) tick();
    rst_n_i = 1'b1;
    tick();
  endtask

  task automatic test_normal_single();
    int waited;
    int held;
    pulse_event(8'h20);
    exp_q.push_back(3'b101);
    checks++;
    if (pending_o !== 8'h20 || irq_o !== 1'b0) begin
      failures++; $display("FAIL single_latch: got pend=%h irq=%b expected 20/0", pending_o, irq_o);
    end
    tick();
    checks++;
    if (irq_o !== 1'b1) begin
      failures++; $display("FAIL single_latency: got irq=%b expected 1", irq_o);
    end
    wait_irq(10, waited);
    exp_id = exp_q.pop_front();
    checks++;
    if (int_id_o !== exp_id) begin
      failures++; $display("FAIL single_id: got %b expected %b", int_id_o, exp_id);
    end
    held = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (irq_o === 1'b1 && int_id_o === exp_id) held++;
    end
    checks++;
    if (held !== 20) begin
      failures++; $display("FAIL single_hold: got %0d cycles expected 20", held);
    end
    pulse_ack();
    checks++;
    if (irq_o !== 1'b0 || pending_o !== 8'h00) begin
      failures++; $display("FAIL single_ack: got irq=%b pend=%h expected 0/00", irq_o, pending_o);
    end
    repeat (2) tick();
  endtask

  task automatic test_same_cycle();
    int waited;
    pulse_event(8'h29);
    exp_q.push_back(3'b011);
    exp_q.push_back(3'b101);
    exp_q.push_back(3'b000);
    for (int n = 0; n < 3; n++) begin
      wait_irq(10, waited);
      checks++;
      if (irq_o !== 1'b1) begin
        failures++; $display("FAIL multi_irq%0d: got %b expected 1", n, irq_o);
      end
      if (n > 0) begin
        checks++;
        if (waited < 2) begin
          failures++; $display("FAIL multi_gap%0d: got %0d low cycles expected >=2", n, waited);
        end
      end
      exp_id = exp_q.pop_front();
      checks++;
      if (int_id_o !== exp_id) begin
        failures++; $display("FAIL multi_id%0d: got %b expected %b", n, int_id_o, exp_id);
      end
      repeat (3) tick();
      pulse_ack();
    end
    checks++;
    if (int_pending_o !== 1'b0 || irq_o !== 1'b0) begin
      failures++; $display("FAIL multi_done: got intpend=%b irq=%b expected 0/0", int_pending_o, irq_o);
    end
    repeat (2) tick();
  endtask

  task automatic test_fast_clear();
    int high;
    response_mode_i = 2'b01;
    pulse_event(8'h02);
    exp_q.push_back(3'b001);
    tick();
    exp_id = exp_q.pop_front();
    checks++;
    if (irq_o !== 1'b1 || int_id_o !== exp_id) begin
      failures++; $display("FAIL fast_irq: got irq=%b id=%b expected 1/%b", irq_o, int_id_o, exp_id);
    end
    tick();
    checks++;
    if (irq_o !== 1'b0 || pending_o !== 8'h00) begin
      failures++; $display("FAIL fast_clear: got irq=%b pend=%h expected 0/00", irq_o, pending_o);
    end
    tick();
    pulse_ack();
    high = 0;
    for (int i = 0; i < 5; i++) begin
      if (irq_o !== 1'b0 || pending_o !== 8'h00) high++;
      tick();
    end
    checks++;
    if (high !== 0) begin
      failures++; $display("FAIL fast_idle_ack: got %0d active cycles expected 0", high);
    end
    response_mode_i = 2'b00;
  endtask

  task automatic test_no_preempt();
    int waited;
    int stable;
    pulse_event(8'h01);
    exp_q.push_back(3'b000);
    wait_irq(10, waited);
    exp_id = exp_q.pop_front();
    checks++;
    if (irq_o !== 1'b1 || int_id_o !== exp_id) begin
      failures++; $display("FAIL preempt_first: got irq=%b id=%b expected 1/%b", irq_o, int_id_o, exp_id);
    end
    // Mode change while waiting must not turn this service into a fast clear.
    response_mode_i = 2'b01;
    pulse_event(8'h04);
    exp_q.push_back(3'b010);
    stable = 0;
    for (int i = 0; i < 5; i++) begin
      if (irq_o === 1'b1 && int_id_o === 3'b000) stable++;
      tick();
    end
    checks++;
    if (stable !== 5) begin
      failures++; $display("FAIL preempt_hold: got %0d stable cycles expected 5", stable);
    end
    checks++;
    if (pending_o !== 8'h05) begin
      failures++; $display("FAIL preempt_pend: got %h expected 05", pending_o);
    end
    response_mode_i = 2'b00;
    pulse_ack();
    tick();
    wait_irq(10, waited);
    exp_id = exp_q.pop_front();
    checks++;
    if (irq_o !== 1'b1 || int_id_o !== exp_id) begin
      failures++; $display("FAIL preempt_second: got irq=%b id=%b expected 1/%b", irq_o, int_id_o, exp_id);
    end
    pulse_ack();
    repeat (2) tick();
  endtask

  task automatic test_mask_drop();
    int waited;
    int fired;
    int_mask_i = 8'hFE;
    pulse_event(8'h01);
    checks++;
    if (pending_o !== 8'h00) begin
      failures++; $display("FAIL mask_drop: got pend=%h expected 00", pending_o);
    end
    int_mask_i = 8'hFF;
    fired = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (irq_o !== 1'b0 || pending_o !== 8'h00) fired++;
    end
    checks++;
    if (fired !== 0) begin
      failures++; $display("FAIL mask_unmask: got %0d active cycles expected 0", fired);
    end
    pulse_event(8'h01);
    exp_q.push_back(3'b000);
    wait_irq(10, waited);
    exp_id = exp_q.pop_front();
    checks++;
    if (irq_o !== 1'b1 || int_id_o !== exp_id) begin
      failures++; $display("FAIL mask_refire: got irq=%b id=%b expected 1/%b", irq_o, int_id_o, exp_id);
    end
    pulse_ack();
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_wait();
    int waited;
    pulse_event(8'h10);
    exp_q.push_back(3'b100);
    wait_irq(10, waited);
    exp_id = exp_q.pop_front();
    checks++;
    if (irq_o !== 1'b1 || int_id_o !== exp_id) begin
      failures++; $display("FAIL rst_serve: got irq=%b id=%b expected 1/%b", irq_o, int_id_o, exp_id);
    end
    pulse_event(8'h40);
`ifdef UART_IRQ_VECTOR_EN
    vectored_i = 1'b1;
    tick();
    checks++;
    if (vector_o !== 8'hFF) begin
      failures++; $display("FAIL vector_on: got %h expected FF", vector_o);
    end
    vectored_i = 1'b0;
    tick();
    checks++;
    if (vector_o !== 8'h00) begin
      failures++; $display("FAIL vector_off: got %h expected 00", vector_o);
    end
    vectored_i = 1'b1;
    tick();
`endif
    #2 rst_n_i = 1'b0;
    #1;
    checks++;
    if (irq_o !== 1'b0 || pending_o !== 8'h00 || int_id_o !== 3'b000) begin
      failures++;
      $display("FAIL rst_mid: got irq=%b pend=%h id=%b expected 0/00/000", irq_o, pending_o, int_id_o);
    end
`ifdef UART_IRQ_VECTOR_EN
    checks++;
    if (vector_o !== 8'h00) begin
      failures++; $display("FAIL rst_vector: got %h expected 00", vector_o);
    end
    vectored_i = 1'b0;
`endif
    tick();
    rst_n_i = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_normal_single();
    test_same_cycle();
    test_fast_clear();
    test_no_preempt();
    test_mask_drop();
    test_reset_mid_wait();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_irq_scheduler.md
Name: uart_irq_scheduler

Overview:
Interrupt arbiter/scheduler for the UART controller. It latches single-cycle interrupt events from the transmitter, receiver, FIFOs and control unit, then selects the highest-priority unmasked pending source. It drives one IRQ line plus the 3-bit INTID for ISR[2:0], and sequences acknowledge/clear according to the interrupt response mode (NORMAL / FAST_CLEAR). It sits between the datapath status logic and the register file (ISR, CTR.INTPEND).

Parameters:
None. INT_* ids, NORMAL/FAST_CLEAR codes, UART_ISR_VECTOR and the normal_interrupt_response_fsm_e states come from uart_pkg.

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous reset, active low
event_i  in  8  one-cycle event pulses; bit index = INT_* id (bit0 TX_DONE … bit7 CONFIG_REQ)
int_mask_i  in  8  1 = source enabled, per INT_* id
response_mode_i  in  2  NORMAL (00) or FAST_CLEAR (01); 10/11 treated as NORMAL
int_ackn_i  in  1  one-cycle acknowledge (ISR read by host)
irq_o  out  1  interrupt request, active high, registered
int_id_o  out  3  id of interrupt being served, registered
pending_o  out  8  pending register contents
int_pending_o  out  1  OR of pending_o (CTR.INTPEND)

Behaviour:
- Reset (async, rst_n_i=0): pending=0, state=IDLE, irq_o=0, int_id_o=3'b000, latched mode=NORMAL.
- Pending latch: pending[i] sets the cycle after event_i[i]=1 AND int_mask_i[i]=1. Masked events are dropped and never fire after a later unmask. A set and a clear of the same bit in the same cycle resolve to set (new event retained).
- Fixed priority, highest first:
  - PRIO1 group: CONFIG_FAIL(001) > OVERRUN(010) > FRAME(011) > PARITY(100)
  - PRIO2 group: RX_FULL(110) > RXD_RDY(101)
  - PRIO3 group: CONFIG_REQ(111) > TX_DONE(000)
- Only bits with pending=1 and mask=1 compete. Clearing a mask bit while its source is pending blocks selection but keeps the pending bit.
- FSM (normal_interrupt_response_fsm_e):
  - IDLE: if any eligible pending, latch winner id into int_id_o, latch response_mode_i, go to PRIOn_WAIT_ACKN for the winner's group; irq_o=1 from the next cycle.
  - PRIOn_WAIT_ACKN, NORMAL: hold irq_o=1 and int_id_o stable until int_ackn_i=1. Then clear pending[int_id_o] and go to PRIOn_CLEAR.
  - PRIOn_WAIT_ACKN, FAST_CLEAR: stay exactly 1 cycle, ignore int_ackn_i, clear pending[int_id_o], go to PRIOn_CLEAR.
  - PRIOn_CLEAR: irq_o=0, int_id_o held; go to IDLE next cycle.
- No preemption: a higher-priority event arriving during WAIT/CLEAR is only latched and is served after return to IDLE.
- Latency: event at cycle N → pending at N+1 → irq_o=1 at N+2.
- Ack at cycle M → irq_o=0 at M+1, IDLE at M+2, next irq_o=1 at M+3 at the earliest. IRQ is therefore low for at least 2 cycles between requests.
- int_ackn_i in IDLE or CLEAR: ignored.
- response_mode_i changes during WAIT/CLEAR take effect only at the next IDLE→WAIT transition.
- int_pending_o is combinational OR of pending.
- Reset mid-service: IRQ drops immediately and all pending is lost.

Optional Feature:
- Macro UART_IRQ_VECTOR_EN.
- When defined, adds ports vectored_i (in, 1, CTR.VECTORED) and vector_o (out, 8).
- vector_o = UART_ISR_VECTOR while irq_o=1 and vectored_i=1, else 8'h00. Registered with irq_o; resets to 8'h00.
- When undefined, neither port exists and behaviour is otherwise identical.

Test Plan:
- Reset, then pulse event_i=8'h20 (RXD_RDY), mask=8'hFF, NORMAL → irq_o=1 two cycles later with int_id_o=3'b101. irq_o stays high 20 cycles without ack. Ack → irq_o=0 next cycle, pending_o=0.
- Same-cycle event_i=8'h29 (TX_DONE, FRAME, RXD_RDY) → served in order 011, 101, 000. Each needs its own ack, irq_o is low ≥2 cycles between them, int_pending_o=0 after the third ack.
- FAST_CLEAR, event_i=8'h02 → irq_o high exactly 1 cycle with int_id_o=001, pending cleared, no ack needed. An ack pulse in IDLE has no effect.
- During PRIO3_WAIT_ACKN serving 000, pulse OVERRUN → int_id_o stays 000 until ack, then 010 is served.
- Mask=8'hFE, pulse event_i bit0 → no pending, no IRQ. Set mask=8'hFF → still no IRQ. Pulse bit0 again → IRQ with id 000.
- Assert rst_n_i low mid-WAIT → irq_o, pending_o, int_id_o all 0 asynchronously. With UART_IRQ_VECTOR_EN, vectored_i=1 and an active IRQ → vector_o=8'hFF; vectored_i=0 → vector_o=8'h00.
